tohost_ctrl: RTL and testbench

//  Synthesizable host-interface controller on the rvbug dmem write channel.
//  - Snoops core data-memory writes and decodes those to TOHOST_ADDR: cmd=wdata[17:16].
//  - Sequences console output through a character FIFO and latches the exit code.
//  - Raises finish after the FIFO drains plus a fixed delay; also keeps cycle/instret counters.

---
 rtl/tohost_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tohost_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tohost_ctrl.sv
// tohost_ctrl: host-interface controller snooping the core dmem write channel.
// Writes to TOHOST_ADDR carry a command in wdata[17:16]: 01 = console put,
// 10 = exit. Console bytes are queued in a first-word-fall-through FIFO.
// An exit latches the exit code, waits for the FIFO to drain plus a fixed
// delay, then raises a sticky finish flag. Cycle/instret counters freeze at finish.
// Optional build macro: TOHOST_DROP_EN (discard puts while full instead of
// back-pressuring the core, and count the discarded bytes).
//
// state | meaning
// RUN   | normal operation, puts queued, exit accepted
// DRAIN | exit seen, writes ignored, waiting for console FIFO to empty
// HOLD  | FIFO empty, counting down the finish delay
// DONE  | finish_o high, counters frozen, terminal until reset
module tohost_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h4000_0000,
  parameter int              FIFO_DEPTH   = 8,
  parameter int              FINISH_DELAY = 2
) (
  input  logic            aclk_i,
  input  logic            areset_ni,
  input  logic            wvalid_i,
  output logic            wready_o,
  input  logic [XLEN-1:0] waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            con_valid_o,
  input  logic            con_ready_i,
  output logic [7:0]      con_data_o,
  input  logic            valid_instr_i,
  output logic            finish_o,
  output logic [15:0]     exit_code_o,
  output logic [63:0]     cycle_o,
  output logic [63:0]     instret_o,
  output logic [15:0]     drop_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  // Delay counter holds FINISH_DELAY-1, which always fits in clog2(FINISH_DELAY) bits.
  localparam int DW = (FINISH_DELAY > 1) ? $clog2(FINISH_DELAY) : 1;
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DLY_LOAD = DW'(FINISH_DELAY - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HOLD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PW:0]     count_q;
  logic [DW-1:0]   dly_q;
  logic            finish_q;
  logic [15:0]     exit_code_q;
  logic [63:0]     cycle_q, instret_q;

  logic hit, put, ext, full, push, pop, drained;
  logic unused_wdata;

  assign hit  = (waddr_i == TOHOST_ADDR);
  assign put  = hit && (wdata_i[17:16] == 2'b01);
  assign ext  = hit && (wdata_i[17:16] == 2'b10);
  assign full = (count_q == DEPTH_C);
  assign unused_wdata = ^wdata_i[XLEN-1:18];

  // State register
  always_ff @(posedge aclk_i) begin
    if (!areset_ni) state_q <= S_RUN;
    else            state_q <= state_d;
  end

  // Next-state logic; a pop of the last byte counts as drained in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (wvalid_i && ext) state_d = S_DRAIN;
      S_DRAIN: if (drained) state_d = (FINISH_DELAY == 1) ? S_DONE : S_HOLD;
      S_HOLD:  if (dly_q <= DW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  // Output / handshake decode
  always_comb begin
    pop     = (count_q != '0) && con_ready_i;
    push    = (state_q == S_RUN) && wvalid_i && put && !full;
    drained = (count_q == '0) || ((count_q == (PW+1)'(1)) && pop);
`ifdef TOHOST_DROP_EN
    wready_o = 1'b1;
`else
    wready_o = !areset_ni || !(put && full && (state_q == S_RUN));
`endif
  end

  // FIFO storage; emptiness is tracked by the pointers so no reset needed here
  always_ff @(posedge aclk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge aclk_i) begin
    if (!areset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Finish delay down-counter, loaded on leaving DRAIN
  always_ff @(posedge aclk_i) begin
    if (!areset_ni)                          dly_q <= '0;
    else if (state_q == S_DRAIN && drained)  dly_q <= DLY_LOAD;
    else if (state_q == S_HOLD && dly_q != '0) dly_q <= dly_q - DW'(1);
  end

  // Exit code, finish flag and free-running counters
  always_ff @(posedge aclk_i) begin
    if (!areset_ni) begin
      exit_code_q <= '0;
      finish_q    <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      if (state_q == S_RUN && wvalid_i && ext) exit_code_q <= wdata_i[15:0];
      finish_q <= (state_d == S_DONE);
      if (state_q != S_DONE) begin
        cycle_q   <= cycle_q + 64'd1;
        instret_q <= instret_q + 64'(valid_instr_i);
      end
    end
  end

`ifdef TOHOST_DROP_EN
  logic [15:0] drop_q;
  logic        drop;
  assign drop = (state_q == S_RUN) && wvalid_i && put && full;

  // Saturating count of console bytes discarded while full
  always_ff @(posedge aclk_i) begin
    if (!areset_ni)                      drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
  assign drop_cnt_o = drop_q;
`else
  assign drop_cnt_o = '0;
`endif

  assign con_valid_o = (count_q != '0);
  assign con_data_o  = mem_q[rd_ptr_q];
  assign finish_o    = finish_q;
  assign exit_code_o = exit_code_q;
  assign cycle_o     = cycle_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_tohost_ctrl.sv
// Self-checking bench for tohost_ctrl: console bytes are checked by a
// scoreboard queue, control/status outputs by directed checks.
module tb_tohost_ctrl;
  localparam int          XLEN   = 32;
  localparam logic [31:0] TOHOST = 32'h4000_0000;

  logic        aclk_i = 1'b0;
  logic        areset_ni, wvalid_i, wready_o, con_valid_o, con_ready_i;
  logic        valid_instr_i, finish_o;
  logic [31:0] waddr_i, wdata_i;
  logic [7:0]  con_data_o;
  logic [15:0] exit_code_o, drop_cnt_o;
  logic [63:0] cycle_o, instret_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [63:0] tb_cyc, tb_inst, exp_cyc, exp_inst;

  tohost_ctrl #(.XLEN(XLEN), .TOHOST_ADDR(TOHOST), .FIFO_DEPTH(8), .FINISH_DELAY(2)) dut (
    .aclk_i(aclk_i), .areset_ni(areset_ni), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .con_valid_o(con_valid_o),
    .con_ready_i(con_ready_i), .con_data_o(con_data_o), .valid_instr_i(valid_instr_i),
    .finish_o(finish_o), .exit_code_o(exit_code_o), .cycle_o(cycle_o),
    .instret_o(instret_o), .drop_cnt_o(drop_cnt_o));

  always #5 aclk_i = ~aclk_i;

  // Reference cycle / retired-instruction counts since the last reset release
  always @(posedge aclk_i) begin
    if (!areset_ni) begin
      tb_cyc  <= '0;
      tb_inst <= '0;
    end else begin
      tb_cyc  <= tb_cyc + 64'd1;
      tb_inst <= tb_inst + 64'(valid_instr_i);
    end
  end

  // Scoreboard monitor: every console handshake must match the queue head
  always @(negedge aclk_i) begin
    if (areset_ni && con_valid_o && con_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL con_data: got %02h, required no byte (queue empty)", con_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (con_data_o !== e) begin
          n_fail++;
          $display("FAIL con_data: got %02h, required %02h", con_data_o, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge aclk_i);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    wvalid_i = 1'b1;
    waddr_i  = a;
    wdata_i  = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge aclk_i);
      if (wready_o) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    wvalid_i = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: got wready_o=0 for 40 cycles, required acceptance");
    end
  endtask

  task automatic put(input logic [7:0] b);
    exp_q.push_back(b);
    do_write(TOHOST, {14'h0, 2'b01, 8'h00, b});
  endtask

  task automatic wait_drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d bytes still expected, required 0", nm, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_ni = 1'b0; wvalid_i = 1'b0; waddr_i = '0; wdata_i = '0;
    con_ready_i = 1'b0; valid_instr_i = 1'b0;
    tick(); tick();
    @(negedge aclk_i);
    chk("wready_in_reset", wready_o, 1);
    tick();
    areset_ni = 1'b1;

    // 1: idle after reset
    repeat (10) @(posedge aclk_i);
    @(negedge aclk_i);
    chk("idle_cycle", cycle_o, 10);
    chk("idle_instret", instret_o, 0);
    chk("idle_finish", finish_o, 0);
    chk("idle_con_valid", con_valid_o, 0);
    chk("idle_wready", wready_o, 1);
    chk("idle_exit_code", exit_code_o, 0);
    tick();
    valid_instr_i = 1'b1;
    repeat (5) tick();
    valid_instr_i = 1'b0;
    @(negedge aclk_i);
    chk("instret_5", instret_o, 5);
    chk("cycle_16", cycle_o, 16);
    tick();

    // 2: single puts with sink ready, one-cycle visibility, non-put writes ignored
    con_ready_i = 1'b1;
    put(8'h48);
    @(negedge aclk_i);
    chk("H_visible", con_valid_o, 1);
    chk("H_data", con_data_o, 8'h48);
    tick();
    put(8'h69);
    @(negedge aclk_i);
    chk("i_visible", con_valid_o, 1);
    chk("i_data", con_data_o, 8'h69);
    tick();
    do_write(TOHOST + 32'd4, 32'h0001_0041);
    do_write(TOHOST, 32'h0003_0042);
    do_write(TOHOST, 32'h0000_0043);
    @(negedge aclk_i);
    chk("ignored_writes_no_byte", con_valid_o, 0);
    tick();

    // 3: fill to depth, backpressure, no bypass, wrap order
    con_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) put(8'h30 + 8'(i));
    exp_q.push_back(8'h38);
    wvalid_i = 1'b1; waddr_i = TOHOST; wdata_i = 32'h0001_0038;
    @(negedge aclk_i);
    chk("full_wready", wready_o, 0);
    chk("full_con_data_head", con_data_o, 8'h30);
    tick();
    con_ready_i = 1'b1;
    @(negedge aclk_i);
    chk("no_bypass_wready", wready_o, 0);
    tick();
    @(negedge aclk_i);
    chk("after_pop_wready", wready_o, 1);
    tick();
    wvalid_i = 1'b0;
    wait_drain("wrap_drain");
    @(negedge aclk_i);
    chk("wrap_empty", con_valid_o, 0);
    chk("drop_cnt_zero", drop_cnt_o, 0);
    tick();

    // 4: exit with 3 bytes queued
    valid_instr_i = 1'b1;
    con_ready_i = 1'b0;
    put(8'h61); put(8'h62); put(8'h63);
    do_write(TOHOST, 32'h0002_002A);
    con_ready_i = 1'b1;
    begin
      int pops;
      pops = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge aclk_i);
        if (con_valid_o && con_ready_i) pops++;
        if (pops == 3) break;
      end
      chk("exit_pops", pops, 3);
    end
    @(negedge aclk_i);
    chk("finish_early", finish_o, 0);
    @(negedge aclk_i);
    chk("finish_at_delay", finish_o, 1);
    chk("exit_code", exit_code_o, 16'h002A);
    exp_cyc  = tb_cyc;
    exp_inst = tb_inst;
    chk("cycle_at_done", cycle_o, exp_cyc);
    chk("instret_at_done", instret_o, exp_inst);
    tick();
    do_write(TOHOST, 32'h0001_007A);
    repeat (3) tick();
    @(negedge aclk_i);
    chk("cycle_frozen", cycle_o, exp_cyc);
    chk("instret_frozen", instret_o, exp_inst);
    chk("finish_sticky", finish_o, 1);
    chk("done_put_ignored", con_valid_o, 0);
    tick();
    valid_instr_i = 1'b0;

    // 5a: exit with empty FIFO -> finish FINISH_DELAY+1 cycles after the write
    areset_ni = 1'b0;
    @(negedge aclk_i);
    chk("wready_in_reset2", wready_o, 1);
    tick();
    areset_ni = 1'b1;
    exp_q.delete();
    do_write(TOHOST, 32'h0002_0055);
    @(negedge aclk_i);
    chk("empty_exit_w1", finish_o, 0);
    tick();
    @(negedge aclk_i);
    chk("empty_exit_w2", finish_o, 0);
    tick();
    @(negedge aclk_i);
    chk("empty_exit_w3", finish_o, 1);
    chk("empty_exit_code", exit_code_o, 16'h0055);
    tick();

    // 5b: reset discards queued bytes
    areset_ni = 1'b0;
    tick();
    areset_ni = 1'b1;
    con_ready_i = 1'b0;
    put(8'h71); put(8'h72);
    areset_ni = 1'b0;
    exp_q.delete();
    tick();
    areset_ni = 1'b1;
    @(negedge aclk_i);
    chk("reset_discard_valid", con_valid_o, 0);
    chk("reset_exit_code", exit_code_o, 0);
    chk("reset_cycle", cycle_o, 0);
    chk("reset_finish", finish_o, 0);
    tick();
    con_ready_i = 1'b1;

    // 5c: reset while in HOLD cancels the pending finish
    do_write(TOHOST, 32'h0002_0077);
    tick();
    areset_ni = 1'b0;
    @(negedge aclk_i);
    chk("hold_reset_wready", wready_o, 1);
    tick();
    areset_ni = 1'b1;
    @(negedge aclk_i);
    chk("hold_reset_exit_code", exit_code_o, 0);
    chk("hold_reset_cycle", cycle_o, 0);
    chk("hold_reset_instret", instret_o, 0);
    chk("hold_reset_drop", drop_cnt_o, 0);
    for (int k = 0; k < 6; k++) begin
      chk("hold_reset_no_finish", finish_o, 0);
      tick();
      @(negedge aclk_i);
    end
    tick();

`ifdef TOHOST_DROP_EN
    // 6: overflow drops instead of back-pressuring
    con_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back(8'h50 + 8'(i));
      wvalid_i = 1'b1; waddr_i = TOHOST; wdata_i = 32'h0001_0050 + 32'(i);
      @(negedge aclk_i);
      chk("drop_wready", wready_o, 1);
      tick();
    end
    wvalid_i = 1'b0;
    @(negedge aclk_i);
    chk("drop_cnt", drop_cnt_o, 2);
    tick();
    con_ready_i = 1'b1;
    wait_drain("drop_drain");
    @(negedge aclk_i);
    chk("drop_empty", con_valid_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
